// File: rtl/axi_light_arb2_pkg.sv
// Shared definitions for the two-requester AXI-Lite arbiter: bus widths,
// arbiter FSM states and the one-hot grant encoding.
package axi_light_arb2_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int STRB_W = 4;
   localparam int RESP_W = 2;

   typedef enum logic [2:0] {
      ST_IDLE         = 3'd0,
      ST_WR_ADDR_DATA = 3'd1,
      ST_WR_RESP      = 3'd2,
      ST_RD_ADDR      = 3'd3,
      ST_RD_RESP      = 3'd4
   } arb_state_t;

   typedef enum logic [1:0] {
      GNT_NONE = 2'b00,
      GNT_P0   = 2'b01,
      GNT_P1   = 2'b10
   } grant_t;

   // One-hot grant for a requester index.
   function automatic grant_t grant_of(input logic idx);
      return idx ? GNT_P1 : GNT_P0;
   endfunction

endpackage

// File: rtl/if_axi_light.sv
// Minimal AXI-Lite bundle (single outstanding transaction, no IDs).
interface if_axi_light;
   import axi_light_arb2_pkg::*;

   logic [ADDR_W-1:0] awaddr;
   logic              awvalid;
   logic              awready;
   logic [DATA_W-1:0] wdata;
   logic [STRB_W-1:0] wstrb;
   logic              wvalid;
   logic              wready;
   logic [RESP_W-1:0] bresp;
   logic              bvalid;
   logic              bready;
   logic [ADDR_W-1:0] araddr;
   logic              arvalid;
   logic              arready;
   logic [DATA_W-1:0] rdata;
   logic [RESP_W-1:0] rresp;
   logic              rvalid;
   logic              rready;

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

endinterface

// File: rtl/axi_light_arb2_rr_arb2.sv
// Two-input pick: round-robin on the last-granted pointer, or fixed priority
// to port 0. The pointer only moves when the pick is actually taken.
module rr_arb2 #(
   parameter int unsigned FIXED_PRIO = 32'd0
) (
   input  logic       clk,
   input  logic       res_n,
   input  logic [1:0] req,
   input  logic       take,
   output logic       pick_valid,
   output logic       pick_idx
);

   logic last;

   // Choose the winner from the current requests and the last-grant pointer.
   always_comb begin
      pick_valid = |req;
      if (req == 2'b11) begin
         pick_idx = (FIXED_PRIO != 32'd0) ? 1'b0 : ~last;
      end else if (req == 2'b10) begin
         pick_idx = 1'b1;
      end else begin
         pick_idx = 1'b0;
      end
   end

   // Last-grant pointer; starts at 1 so port 0 wins the first contention.
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         last <= 1'b1;
      end else if (take && pick_valid) begin
         last <= pick_idx;
      end else begin
         last <= last;
      end
   end

endmodule

// File: rtl/axi_light_arb2.sv
// Arbitrates two AXI-Lite requesters onto one downstream port, one
// transaction at a time. Channels are routed combinationally to the owner.
module axi_light_arb2
   import axi_light_arb2_pkg::*;
#(
   parameter int unsigned FIXED_PRIO = 32'd0,
   parameter int unsigned CNT_WIDTH  = 32'd16
) (
   input  logic                 clk,
   input  logic                 res_n,
   if_axi_light.slave           s_axi_0,
   if_axi_light.slave           s_axi_1,
   if_axi_light.master          m_axi,
   output logic [1:0]           grant,
   output logic                 busy,
   output logic [CNT_WIDTH-1:0] grant_cnt_0,
   output logic [CNT_WIDTH-1:0] grant_cnt_1
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1'b1);

   arb_state_t state, state_nx;
   grant_t     grant_q, grant_nx;
   logic       aw_done, aw_done_nx, w_done, w_done_nx;
   logic       take, pick_valid, pick_idx, sel, win_aw;
   logic       in_wr, in_wr_resp, in_rd, in_rd_resp;
   logic       own_awvalid, own_wvalid, own_arvalid, own_bready, own_rready;
   logic [1:0] req;
   logic [CNT_WIDTH-1:0] cnt_0, cnt_1;

   assign req = {s_axi_1.awvalid | s_axi_1.arvalid, s_axi_0.awvalid | s_axi_0.arvalid};

   rr_arb2 #(.FIXED_PRIO(FIXED_PRIO)) u_rr_arb2 (
      .clk        (clk),
      .res_n      (res_n),
      .req        (req),
      .take       (take),
      .pick_valid (pick_valid),
      .pick_idx   (pick_idx)
   );

   // Owner select: grant is 00 in IDLE, so idle muxes fall back to port 0.
   assign sel        = grant_q[1];
   assign win_aw     = pick_idx ? s_axi_1.awvalid : s_axi_0.awvalid;
   assign in_wr      = (state == ST_WR_ADDR_DATA);
   assign in_wr_resp = (state == ST_WR_RESP);
   assign in_rd      = (state == ST_RD_ADDR);
   assign in_rd_resp = (state == ST_RD_RESP);

   assign own_awvalid = sel ? s_axi_1.awvalid : s_axi_0.awvalid;
   assign own_wvalid  = sel ? s_axi_1.wvalid  : s_axi_0.wvalid;
   assign own_arvalid = sel ? s_axi_1.arvalid : s_axi_0.arvalid;
   assign own_bready  = sel ? s_axi_1.bready  : s_axi_0.bready;
   assign own_rready  = sel ? s_axi_1.rready  : s_axi_0.rready;

   // Downstream port: payload always muxed, valids/readies gated by state.
   assign m_axi.awaddr  = sel ? s_axi_1.awaddr : s_axi_0.awaddr;
   assign m_axi.wdata   = sel ? s_axi_1.wdata  : s_axi_0.wdata;
   assign m_axi.wstrb   = sel ? s_axi_1.wstrb  : s_axi_0.wstrb;
   assign m_axi.araddr  = sel ? s_axi_1.araddr : s_axi_0.araddr;
   assign m_axi.awvalid = in_wr & ~aw_done & own_awvalid;
   assign m_axi.wvalid  = in_wr & ~w_done & own_wvalid;
   assign m_axi.arvalid = in_rd & own_arvalid;
   assign m_axi.bready  = in_wr_resp & own_bready;
   assign m_axi.rready  = in_rd_resp & own_rready;

   // Requester 0 side: only the owner ever sees ready/valid from downstream.
   assign s_axi_0.awready = ~sel & in_wr & ~aw_done & m_axi.awready;
   assign s_axi_0.wready  = ~sel & in_wr & ~w_done & m_axi.wready;
   assign s_axi_0.arready = ~sel & in_rd & m_axi.arready;
   assign s_axi_0.bvalid  = ~sel & in_wr_resp & m_axi.bvalid;
   assign s_axi_0.rvalid  = ~sel & in_rd_resp & m_axi.rvalid;
   assign s_axi_0.bresp   = m_axi.bresp;
   assign s_axi_0.rdata   = m_axi.rdata;
   assign s_axi_0.rresp   = m_axi.rresp;

   // Requester 1 side.
   assign s_axi_1.awready = sel & in_wr & ~aw_done & m_axi.awready;
   assign s_axi_1.wready  = sel & in_wr & ~w_done & m_axi.wready;
   assign s_axi_1.arready = sel & in_rd & m_axi.arready;
   assign s_axi_1.bvalid  = sel & in_wr_resp & m_axi.bvalid;
   assign s_axi_1.rvalid  = sel & in_rd_resp & m_axi.rvalid;
   assign s_axi_1.bresp   = m_axi.bresp;
   assign s_axi_1.rdata   = m_axi.rdata;
   assign s_axi_1.rresp   = m_axi.rresp;

   // Next-state, next-grant and write-progress flags.
   always_comb begin
      state_nx   = state;
      grant_nx   = grant_q;
      aw_done_nx = aw_done;
      w_done_nx  = w_done;
      take       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (pick_valid) begin
               take     = 1'b1;
               grant_nx = grant_of(pick_idx);
               state_nx = win_aw ? ST_WR_ADDR_DATA : ST_RD_ADDR;
            end else begin
               grant_nx = GNT_NONE;
            end
         end
         ST_WR_ADDR_DATA: begin
            aw_done_nx = aw_done | (m_axi.awvalid & m_axi.awready);
            w_done_nx  = w_done | (m_axi.wvalid & m_axi.wready);
            if (aw_done_nx && w_done_nx) begin
               state_nx = ST_WR_RESP;
            end else begin
               state_nx = ST_WR_ADDR_DATA;
            end
         end
         ST_WR_RESP: begin
            if (m_axi.bvalid && m_axi.bready) begin
               state_nx   = ST_IDLE;
               grant_nx   = GNT_NONE;
               aw_done_nx = 1'b0;
               w_done_nx  = 1'b0;
            end else begin
               state_nx = ST_WR_RESP;
            end
         end
         ST_RD_ADDR: begin
            if (m_axi.arvalid && m_axi.arready) begin
               state_nx = ST_RD_RESP;
            end else begin
               state_nx = ST_RD_ADDR;
            end
         end
         ST_RD_RESP: begin
            if (m_axi.rvalid && m_axi.rready) begin
               state_nx = ST_IDLE;
               grant_nx = GNT_NONE;
            end else begin
               state_nx = ST_RD_RESP;
            end
         end
         default: begin
            state_nx   = ST_IDLE;
            grant_nx   = GNT_NONE;
            aw_done_nx = 1'b0;
            w_done_nx  = 1'b0;
         end
      endcase
   end

   // FSM state, owner, busy and write-progress registers.
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         state   <= ST_IDLE;
         grant_q <= GNT_NONE;
         busy    <= 1'b0;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else begin
         state   <= state_nx;
         grant_q <= grant_nx;
         busy    <= (state_nx != ST_IDLE);
         aw_done <= aw_done_nx;
         w_done  <= w_done_nx;
      end
   end

   // Saturating per-port grant counters, bumped in the grant cycle.
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         cnt_0 <= '0;
         cnt_1 <= '0;
      end else if (take) begin
         cnt_0 <= (!pick_idx && cnt_0 != CNT_MAX) ? cnt_0 + CNT_ONE : cnt_0;
         cnt_1 <= ( pick_idx && cnt_1 != CNT_MAX) ? cnt_1 + CNT_ONE : cnt_1;
      end else begin
         cnt_0 <= cnt_0;
         cnt_1 <= cnt_1;
      end
   end

   assign grant       = grant_q;
   assign grant_cnt_0 = cnt_0;
   assign grant_cnt_1 = cnt_1;

endmodule

// File: tb/tb_axi_light_arb2.sv
// Bench for axi_light_arb2: a round-robin instance driven by random
// requesters and a random downstream slave, checked every cycle against a
// phase-level reference model; plus a fixed-priority, 2-bit-counter instance
// with both ports requesting continuously.
module tb_axi_light_arb2;
   import axi_light_arb2_pkg::*;

   localparam int PH_WR = 0, PH_WRESP = 1, PH_RD = 2, PH_RRESP = 3;

   logic clk = 1'b0;
   logic res_n = 1'b0;
   always #5 clk = ~clk;

   if_axi_light s0 (), s1 (), mm ();
   if_axi_light f0 (), f1 (), fm ();

   logic [1:0]  grant_a, grant_b;
   logic        busy_a, busy_b;
   logic [15:0] c0a, c1a;
   logic [1:0]  c0b, c1b;

   axi_light_arb2 #(.FIXED_PRIO(0), .CNT_WIDTH(16)) dut_rr (
      .clk(clk), .res_n(res_n), .s_axi_0(s0), .s_axi_1(s1), .m_axi(mm),
      .grant(grant_a), .busy(busy_a), .grant_cnt_0(c0a), .grant_cnt_1(c1a));

   axi_light_arb2 #(.FIXED_PRIO(1), .CNT_WIDTH(2)) dut_fp (
      .clk(clk), .res_n(res_n), .s_axi_0(f0), .s_axi_1(f1), .m_axi(fm),
      .grant(grant_b), .busy(busy_b), .grant_cnt_0(c0b), .grant_cnt_1(c1b));

   int n_cmp = 0;
   int n_err = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // requester state
   logic        aw_pend[2], w_pend[2], ar_pend[2], b_wait[2], r_wait[2];
   logic [31:0] wr_addr[2], wr_data[2], rd_addr[2];
   logic        bready_d[2], rready_d[2];
   int          new_pct, kinds;
   // downstream slave state
   logic        sl_awready, sl_wready, sl_arready, sl_got_aw, sl_got_w, sl_got_ar;
   logic        sl_bvalid, sl_rvalid, hold_r;
   logic [31:0] sl_rdata;
   logic [1:0]  sl_bresp, sl_rresp;
   int          smode, lag, n_aw_hs, n_w_hs;
   // reference model
   logic        md_busy, md_awd, md_wd;
   int          md_owner, md_phase, md_last;
   int          md_cnt[2];
   logic [1:0]  md_grant, prev_grant;
   logic [1:0]  glog[$];

   task automatic clear_state();
      for (int p = 0; p < 2; p++) begin
         aw_pend[p] = 1'b0; w_pend[p] = 1'b0; ar_pend[p] = 1'b0;
         b_wait[p] = 1'b0; r_wait[p] = 1'b0; bready_d[p] = 1'b0; rready_d[p] = 1'b0;
         wr_addr[p] = 32'h0; wr_data[p] = 32'h0; rd_addr[p] = 32'h0;
         md_cnt[p] = 0;
      end
      sl_got_aw = 1'b0; sl_got_w = 1'b0; sl_got_ar = 1'b0;
      sl_bvalid = 1'b0; sl_rvalid = 1'b0; sl_rdata = 32'h0;
      sl_bresp = 2'b00; sl_rresp = 2'b00; lag = 0;
      md_busy = 1'b0; md_awd = 1'b0; md_wd = 1'b0; md_owner = 0; md_phase = PH_WR;
      md_last = 1; md_grant = 2'b00; prev_grant = 2'b00;
   endtask

   task automatic load_wr(input int p, input logic [31:0] a, input logic [31:0] d);
      aw_pend[p] = 1'b1; w_pend[p] = 1'b1; b_wait[p] = 1'b1;
      wr_addr[p] = a; wr_data[p] = d;
   endtask

   task automatic load_rd(input int p, input logic [31:0] a);
      ar_pend[p] = 1'b1; r_wait[p] = 1'b1; rd_addr[p] = a;
   endtask

   function automatic logic req_idle(input int p);
      return !(aw_pend[p] || w_pend[p] || ar_pend[p] || b_wait[p] || r_wait[p]);
   endfunction

   task automatic drive_inputs();
      int k;
      for (int p = 0; p < 2; p++) begin
         if (req_idle(p) && ($urandom_range(99) < new_pct)) begin
            k = (kinds == 1) ? 1 : int'($urandom_range(2));
            if (k != 1) load_wr(p, $urandom & 32'hFFFF_FFFC, $urandom);
            if (k != 0) load_rd(p, $urandom & 32'hFFFF_FFFC);
         end
         bready_d[p] = ($urandom_range(3) != 0);
         rready_d[p] = ($urandom_range(3) != 0);
      end
      case (smode)
         1: begin
            sl_wready  = !sl_got_w;
            sl_awready = !sl_got_aw && sl_got_w && (lag >= 2);
            sl_arready = !sl_got_ar;
         end
         2: begin
            sl_awready = !sl_got_aw; sl_wready = !sl_got_w; sl_arready = !sl_got_ar;
         end
         default: begin
            sl_awready = !sl_got_aw && ($urandom_range(1) == 1);
            sl_wready  = !sl_got_w  && ($urandom_range(1) == 1);
            sl_arready = !sl_got_ar && ($urandom_range(1) == 1);
         end
      endcase
      s0.awvalid = aw_pend[0]; s0.awaddr = wr_addr[0]; s0.wvalid = w_pend[0];
      s0.wdata = wr_data[0]; s0.wstrb = 4'hF; s0.arvalid = ar_pend[0];
      s0.araddr = rd_addr[0]; s0.bready = bready_d[0]; s0.rready = rready_d[0];
      s1.awvalid = aw_pend[1]; s1.awaddr = wr_addr[1]; s1.wvalid = w_pend[1];
      s1.wdata = wr_data[1]; s1.wstrb = 4'hF; s1.arvalid = ar_pend[1];
      s1.araddr = rd_addr[1]; s1.bready = bready_d[1]; s1.rready = rready_d[1];
      mm.awready = sl_awready; mm.wready = sl_wready; mm.arready = sl_arready;
      mm.bvalid = sl_bvalid; mm.bresp = sl_bresp;
      mm.rvalid = sl_rvalid; mm.rdata = sl_rdata; mm.rresp = sl_rresp;
   endtask

   // Check DUT against the model, then advance bench and model by one clock.
   task automatic evaluate();
      int o, w;
      logic e_awv, e_wv, e_arv, e_br, e_rr, own, r0, r1;
      logic aw_hs, w_hs, ar_hs, b_hs, r_hs;
      logic [4:0] exp5, got5;
      o = md_owner;
      e_awv = md_busy && md_phase == PH_WR && !md_awd && aw_pend[o];
      e_wv  = md_busy && md_phase == PH_WR && !md_wd && w_pend[o];
      e_arv = md_busy && md_phase == PH_RD && ar_pend[o];
      e_br  = md_busy && md_phase == PH_WRESP && bready_d[o];
      e_rr  = md_busy && md_phase == PH_RRESP && rready_d[o];
      check_val("grant", grant_a, md_grant);
      check_val("busy", busy_a, md_busy);
      check_val("cnt0", c0a, md_cnt[0]);
      check_val("cnt1", c1a, md_cnt[1]);
      check_val("m_ctrl", {mm.awvalid, mm.wvalid, mm.arvalid, mm.bready, mm.rready},
                {e_awv, e_wv, e_arv, e_br, e_rr});
      for (int p = 0; p < 2; p++) begin
         own  = md_busy && (o == p);
         exp5 = {own && md_phase == PH_WR && !md_awd && sl_awready,
                 own && md_phase == PH_WR && !md_wd && sl_wready,
                 own && md_phase == PH_RD && sl_arready,
                 own && md_phase == PH_WRESP && sl_bvalid,
                 own && md_phase == PH_RRESP && sl_rvalid};
         got5 = (p == 0) ? {s0.awready, s0.wready, s0.arready, s0.bvalid, s0.rvalid}
                         : {s1.awready, s1.wready, s1.arready, s1.bvalid, s1.rvalid};
         check_val((p == 0) ? "s0_ctrl" : "s1_ctrl", got5, exp5);
      end
      if (e_awv) check_val("m_awaddr", mm.awaddr, wr_addr[o]);
      if (e_wv)  check_val("m_wdata", mm.wdata, wr_data[o]);
      if (e_arv) check_val("m_araddr", mm.araddr, rd_addr[o]);
      if (md_busy && md_phase == PH_WRESP && sl_bvalid)
         check_val("bresp", (o == 0) ? s0.bresp : s1.bresp, sl_bresp);
      if (md_busy && md_phase == PH_RRESP && sl_rvalid)
         check_val("rdata", (o == 0) ? s0.rdata : s1.rdata, sl_rdata);
      if (!md_busy) check_val("idle_awaddr", mm.awaddr, wr_addr[0]);
      if (grant_a != 2'b00 && prev_grant == 2'b00) glog.push_back(grant_a);
      prev_grant = grant_a;

      aw_hs = e_awv && sl_awready;
      w_hs  = e_wv && sl_wready;
      ar_hs = e_arv && sl_arready;
      b_hs  = e_br && sl_bvalid;
      r_hs  = e_rr && sl_rvalid;
      // model: arbitration when idle, otherwise phase progress
      if (!md_busy) begin
         r0 = aw_pend[0] || ar_pend[0];
         r1 = aw_pend[1] || ar_pend[1];
         if (r0 || r1) begin
            w = (r0 && r1) ? (1 - md_last) : (r0 ? 0 : 1);
            md_last = w; md_busy = 1'b1; md_owner = w;
            md_phase = aw_pend[w] ? PH_WR : PH_RD;
            md_awd = 1'b0; md_wd = 1'b0;
            if (md_cnt[w] < 65535) md_cnt[w]++;
            md_grant = (w == 1) ? 2'b10 : 2'b01;
         end
      end else begin
         case (md_phase)
            PH_WR: begin
               md_awd = md_awd || aw_hs; md_wd = md_wd || w_hs;
               if (md_awd && md_wd) md_phase = PH_WRESP;
            end
            PH_WRESP: if (b_hs) begin md_busy = 1'b0; md_grant = 2'b00; end
            PH_RD:    if (ar_hs) md_phase = PH_RRESP;
            default:  if (r_hs) begin md_busy = 1'b0; md_grant = 2'b00; end
         endcase
      end
      // requesters
      if (aw_hs) aw_pend[o] = 1'b0;
      if (w_hs)  w_pend[o]  = 1'b0;
      if (ar_hs) ar_pend[o] = 1'b0;
      if (b_hs)  b_wait[o]  = 1'b0;
      if (r_hs)  r_wait[o]  = 1'b0;
      // downstream slave
      if (aw_hs) begin sl_got_aw = 1'b1; n_aw_hs++; end
      if (w_hs) begin sl_got_w = 1'b1; lag = 0; n_w_hs++; end
      else if (sl_got_w) lag++;
      if (ar_hs) sl_got_ar = 1'b1;
      if (b_hs) begin sl_bvalid = 1'b0; sl_got_aw = 1'b0; sl_got_w = 1'b0; end
      if (r_hs) begin sl_rvalid = 1'b0; sl_got_ar = 1'b0; end
      if (sl_got_aw && sl_got_w && !sl_bvalid && (smode == 2 || $urandom_range(2) == 0)) begin
         sl_bvalid = 1'b1; sl_bresp = 2'($urandom_range(3));
      end
      if (sl_got_ar && !sl_rvalid && !hold_r && (smode == 2 || $urandom_range(2) == 0)) begin
         sl_rvalid = 1'b1; sl_rdata = $urandom; sl_rresp = 2'($urandom_range(3));
      end
   endtask

   task automatic step();
      @(negedge clk);
      drive_inputs();
      #1;
      evaluate();
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while ((md_busy || !req_idle(0) || !req_idle(1)) && n < 300) begin
         step();
         n++;
      end
      check_val(tag, (n >= 300), 1'b0);
   endtask

   // Fixed-priority instance: both ports read continuously.
   int fp_p1_grants = 0, fp_p1_evt = 0, fp_p0_resp = 0;
   initial begin
      f0.awvalid = 1'b0; f0.awaddr = 32'h0; f0.wvalid = 1'b0; f0.wdata = 32'h0; f0.wstrb = 4'h0;
      f0.arvalid = 1'b1; f0.araddr = 32'h10; f0.bready = 1'b1; f0.rready = 1'b1;
      f1.awvalid = 1'b0; f1.awaddr = 32'h0; f1.wvalid = 1'b0; f1.wdata = 32'h0; f1.wstrb = 4'h0;
      f1.arvalid = 1'b1; f1.araddr = 32'h20; f1.bready = 1'b1; f1.rready = 1'b1;
      fm.awready = 1'b1; fm.wready = 1'b1; fm.arready = 1'b1; fm.bvalid = 1'b0; fm.bresp = 2'b00;
      fm.rvalid = 1'b1; fm.rdata = 32'h1234_5678; fm.rresp = 2'b00;
   end

   // Monitor of the fixed-priority instance, sampled mid-low-phase.
   always @(negedge clk) begin
      #1;
      if (res_n) begin
         if (grant_b == 2'b10) fp_p1_grants++;
         if (f1.rvalid || f1.arready) fp_p1_evt++;
         if (f0.rvalid && f0.rready) fp_p0_resp++;
      end
   end

   initial begin
      int n;
      logic [1:0] exp_order[3];
      clear_state();
      new_pct = 0; kinds = 0; smode = 0; hold_r = 1'b0; n_aw_hs = 0; n_w_hs = 0;
      @(negedge clk);
      drive_inputs();
      #1;
      check_val("rst_grant", grant_a, 2'b00);
      check_val("rst_busy", busy_a, 1'b0);
      check_val("rst_cnt", {c0a, c1a}, 32'h0);
      @(negedge clk);
      res_n = 1'b1;

      // port 1 lone write
      load_wr(1, 32'h0000_0100, 32'hDEAD_BEEF);
      drain("drain_lone_wr");
      check_val("lone_first_grant", (glog.size() > 0) ? glog[0] : 2'b11, 2'b10);
      check_val("lone_cnt1", c1a, 16'd1);
      check_val("lone_cnt0", c0a, 16'd0);
      check_val("lone_aw_count", n_aw_hs, 1);

      // continuous read contention: 0,1,0
      glog.delete();
      kinds = 1; new_pct = 100;
      load_rd(0, 32'h40); load_rd(1, 32'h80);
      n = 0;
      while (glog.size() < 3 && n < 200) begin step(); n++; end
      new_pct = 0;
      drain("drain_rr");
      exp_order[0] = 2'b01; exp_order[1] = 2'b10; exp_order[2] = 2'b01;
      for (int i = 0; i < 3; i++)
         check_val("rr_order", (i < glog.size()) ? glog[i] : 2'b11, exp_order[i]);

      // W three cycles ahead of AW, then AW and W in the same cycle
      for (int m = 1; m <= 2; m++) begin
         smode = m;
         n_aw_hs = 0; n_w_hs = 0;
         load_wr(0, 32'h200 + m, 32'hA5A5_0000 + m);
         drain("drain_order_wr");
         check_val("order_wr_aw_once", n_aw_hs, 1);
         check_val("order_wr_w_once", n_w_hs, 1);
      end

      // random traffic
      smode = 0; kinds = 0; new_pct = 30;
      repeat (1500) step();
      new_pct = 0;
      drain("drain_rand1");

      // reset during RD_RESP
      hold_r = 1'b1;
      load_rd(1, 32'h300);
      n = 0;
      while (!(md_busy && md_phase == PH_RRESP) && n < 100) begin step(); n++; end
      check_val("reach_rresp", (n >= 100), 1'b0);
      @(negedge clk);
      drive_inputs();
      mm.rvalid = 1'b1;
      res_n = 1'b0;
      #1;
      check_val("rst_mid_grant", grant_a, 2'b00);
      check_val("rst_mid_busy", busy_a, 1'b0);
      check_val("rst_mid_rvalid", {s0.rvalid, s1.rvalid, mm.rready}, 3'b000);
      check_val("rst_mid_mvalid", {mm.awvalid, mm.wvalid, mm.arvalid}, 3'b000);
      check_val("rst_mid_cnt", {c0a, c1a}, 32'h0);
      @(negedge clk);
      clear_state();
      hold_r = 1'b0;
      drive_inputs();
      res_n = 1'b1;
      load_rd(0, 32'h400);
      drain("drain_after_rst");
      check_val("after_rst_cnt0", c0a, 16'd1);

      new_pct = 30;
      repeat (300) step();
      new_pct = 0;
      drain("drain_rand2");

      // fixed-priority, saturating 2-bit counter instance
      check_val("fp_cnt0", c0b, 2'd3);
      check_val("fp_cnt1", c1b, 2'd0);
      check_val("fp_p1_grants", fp_p1_grants, 0);
      check_val("fp_p1_events", fp_p1_evt, 0);
      check_val("fp_p0_resp_ge5", (fp_p0_resp >= 5), 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
